// File: rtl/logic_result_stage_if.sv
// Handshake bundle between the AND/OR logic unit, logic_result_stage and the writeback path.
// master drives operands and out_ready; slave is the result stage itself.
interface logic_result_stage_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] zand;
    logic [WIDTH-1:0] zor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, op, zand, zor, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg, count
    );

    modport slave (
        input  in_valid, op, zand, zor, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg, count
    );
endinterface

// File: rtl/logic_result_stage.sv
// Final logic-result select with zero/neg flags, buffered in a small registered FIFO.
// Optional LOGIC_RESULT_STATS_EN adds saturating push / zero-result counters.
module logic_result_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    logic_result_stage_if.slave bus
`ifdef LOGIC_RESULT_STATS_EN
    ,
    output logic [15:0]         acc_count,
    output logic [15:0]         zero_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 2;

    logic [WIDTH-1:0] result;
    logic             res_zero;
    logic             res_neg;
    logic             in_rdy;
    logic             out_vld;
    logic             push;
    logic             pop;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;

    // XOR and NOR are rebuilt from the unit's AND/OR outputs
    always_comb begin
        result = '0;
        case (bus.op)
            2'b00:   result = bus.zand;
            2'b01:   result = bus.zor;
            2'b10:   result = bus.zor & ~bus.zand;
            default: result = ~bus.zor;
        endcase
    end

    assign res_zero = (result == '0);
    assign res_neg  = result[WIDTH-1];

    // No pass-through when full; held low for the whole reset pulse
    assign in_rdy  = !rst && (count_q < CW'(DEPTH));
    assign out_vld = (count_q != '0);
    assign push    = bus.in_valid && in_rdy;
    assign pop     = out_vld && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {result, res_zero, res_neg};
    end

    assign head = mem[rd_ptr];

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.count     = count_q;
    assign bus.out_data  = out_vld ? head[EW-1:2] : '0;
    assign bus.out_zero  = out_vld ? head[1] : 1'b0;
    assign bus.out_neg   = out_vld ? head[0] : 1'b0;

`ifdef LOGIC_RESULT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_count  <= '0;
            zero_count <= '0;
        end else if (push) begin
            if (acc_count != '1)              acc_count  <= acc_count + 16'd1;
            if (res_zero && zero_count != '1) zero_count <= zero_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_logic_result_stage.sv
// Scoreboard bench for logic_result_stage: directed pushes queue expected entries,
// a monitor pops and compares whenever the head is consumed.
module tb_logic_result_stage;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       z;
        logic       n;
    } exp_t;

    exp_t exp_q[$];

    logic_result_stage_if #(.WIDTH(8), .DEPTH(2)) bus ();

`ifdef LOGIC_RESULT_STATS_EN
    logic [15:0] acc_count;
    logic [15:0] zero_count;
`endif

    logic_result_stage #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef LOGIC_RESULT_STATS_EN
        ,
        .acc_count  (acc_count),
        .zero_count (zero_count)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one vector at the falling edge; queue its expected entry if accepted
    task automatic drive(input logic [1:0] o, input logic [7:0] a, input logic [7:0] r,
                         input logic [7:0] e, output bit acc);
        exp_t ex;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.zand     = a;
        bus.zor      = r;
        #1;
        acc = bus.in_ready;
        if (acc) begin
            ex.d = e;
            ex.z = (e == 8'h00);
            ex.n = e[7];
            exp_q.push_back(ex);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        while (bus.count != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_count", bus.count, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_count",     bus.count,     0);
`ifdef LOGIC_RESULT_STATS_EN
        chk("rst_acc_count",  acc_count,  0);
        chk("rst_zero_count", zero_count, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
    endtask

    // Monitor: compare the head whenever it will be consumed at the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %0h with empty scoreboard", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.d);
                        chk("out_zero", bus.out_zero, e.z);
                        chk("out_neg",  bus.out_neg,  e.n);
                    end
                end else if (!bus.out_valid) begin
                    chk("empty_out", {bus.out_data, bus.out_zero, bus.out_neg}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ops4 [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] exp4 [4]  = '{8'h0C, 8'h3E, 8'h32, 8'hC1};
        logic [7:0] bp_v [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] s_op [10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00,
                                  2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [7:0] s_a  [10] = '{8'hA5, 8'h00, 8'h0F, 8'h00, 8'h01,
                                  8'h00, 8'h55, 8'h00, 8'h10, 8'h12};
        logic [7:0] s_r  [10] = '{8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h01,
                                  8'h00, 8'h55, 8'h00, 8'h39, 8'h5A};
        logic [7:0] s_e  [10] = '{8'hA5, 8'h7F, 8'hF0, 8'h7F, 8'h01,
                                  8'h00, 8'h00, 8'hFF, 8'h29, 8'hA5};
        bit acc;
        int accepted;

        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.zand      = '0;
        bus.zor       = '0;
        bus.out_ready = 1'b0;

        do_reset();
        mon_en = 1'b1;

        // Opcode decode on zand=0C, zor=3E
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(ops4[i], 8'h0C, 8'h3E, exp4[i], acc);
            chk("op_accept", acc, 1);
        end
        idle();
        drain();

        // Zero flag
        drive(2'b00, 8'h00, 8'hFF, 8'h00, acc);
        chk("zero_accept", acc, 1);
        idle();
        drain();

        // Backpressure: only two of four attempts fit
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 8'h00, bp_v[i], bp_v[i], acc);
            if (acc) accepted++;
        end
        chk("bp_accepted", accepted, 2);
        chk("bp_count",    bus.count, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_count_after_pop", bus.count, 1);
        chk("bp_ready_after_pop", bus.in_ready, 1);
        drain();

        // Streaming with wrap-around
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(s_op[i], s_a[i], s_r[i], s_e[i], acc);
            chk("stream_accept", acc, 1);
            if (i > 0) chk("stream_count", bus.count, 1);
        end
        idle();
        drain();

        // Reset with entries in flight
        bus.out_ready = 1'b0;
        drive(2'b01, 8'h00, 8'h5A, 8'h5A, acc);
        drive(2'b01, 8'h00, 8'hA5, 8'hA5, acc);
        chk("pre_rst_count", bus.count, 1);
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_count", bus.count, 0);

`ifdef LOGIC_RESULT_STATS_EN
        bus.out_ready = 1'b1;
        drive(2'b00, 8'h00, 8'hFF, 8'h00, acc);
        drive(2'b01, 8'h00, 8'h80, 8'h80, acc);
        drive(2'b01, 8'h00, 8'h01, 8'h01, acc);
        idle();
        #1;
        chk("stats_acc",  acc_count,  3);
        chk("stats_zero", zero_count, 1);
        do_reset();
        chk("stats_acc_cleared",  acc_count,  0);
        chk("stats_zero_cleared", zero_count, 0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_result_stage.md
Name: logic_result_stage

Overview:
- Downstream consumer of the 8-bit AND/OR unit. Takes its per-bit Zand/Zor outputs and a 2-bit opcode, and forms the final logic result.
- Derives zero/negative flags and buffers results in a small registered FIFO with valid/ready handshakes on both sides.
- Decouples the combinational logic unit from the writeback path of the CPU datapath.

Parameters:
- WIDTH, 8, data width; must match the AND/OR unit width.
- DEPTH, 2, result FIFO depth in entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operands and op are valid this cycle.
- in_ready  output  1  stage can accept an entry this cycle.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- zand  input  WIDTH  bitwise AND from the logic unit.
- zor  input  WIDTH  bitwise OR from the logic unit.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes head entry.
- out_data  output  WIDTH  head entry result.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Result select, combinational on the input side:
  - AND = zand
  - OR = zor
  - XOR = zor & ~zand
  - NOR = ~zor
- zero and neg are computed from the selected result. Each FIFO entry stores {result, zero, neg}.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH). There is no pass-through when full: a full FIFO deasserts in_ready even if a pop happens that cycle.
- out_valid = (count != 0).
- out_data/out_zero/out_neg are driven from the registered head entry. When empty they are 0.
- Latency: an entry pushed at edge N is visible on out_* after edge N; it is poppable in cycle N+1. Minimum input-to-output latency is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, both pointers advance, and order is preserved.
- Push into empty with no pop: count becomes 1 and out_valid rises next cycle.
- Pop of last entry with no push: count becomes 0 and out_* return to 0 next cycle.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count tracks fullness, so no ambiguity arises.
- in_valid while in_ready=0: no state change. Upstream must hold its inputs stable.
- out_ready while out_valid=0: ignored.
- Reset, asynchronous at any time including mid-transfer:
  - count=0, pointers=0, out_valid=0, out_data=0, out_zero=0, out_neg=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
  - Entries in flight are discarded.
- Storage contents need no reset. Output muxing guarantees the zero values on out_* when empty.

Optional Feature:
- LOGIC_RESULT_STATS_EN defined:
  - Adds output ports acc_count (16 bits) and zero_count (16 bits).
  - acc_count increments on every push and saturates at 0xFFFF.
  - zero_count increments on every push whose result is zero and saturates at 0xFFFF.
  - Both counters are cleared to 0 by rst.
- Not defined: the ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> out_valid=0, out_data=0x00, count=0, in_ready=0 during rst and 1 after.
- Opcode decode, zand=0x0C, zor=0x3E, one push per op with out_ready=1 -> out_data sequence 0x0C, 0x3E, 0x32, 0xC1. out_neg asserted only for 0xC1; out_zero always 0.
- Zero flag: op=00, zand=0x00, zor=0xFF -> out_data=0x00, out_zero=1, out_neg=0.
- Backpressure: out_ready=0, four push attempts with DEPTH=2 -> only the first two accepted, in_ready=0 and count=2. Then out_ready=1 -> the two entries pop in order and in_ready=1 on the cycle after count drops below 2.
- Streaming: continuous push/pop with in_valid=1, out_ready=1 for 10 entries -> count stays 1, no loss or reordering, pointer wrap exercised.
- With LOGIC_RESULT_STATS_EN: 3 pushes, one zero result, then rst mid-stream -> acc_count=3 and zero_count=1 before reset; both 0 after.
